// File: rtl/pipelined_barrel_shifter.sv
// Pipelined multi-mode barrel shifter (LSL / LSR / ASR / ROR).
// One register stage per shift-amount bit. Stage k conditionally shifts by 2^k.
// Each stage has a valid/ready handshake, and ready is computed per stage so bubbles collapse.
// Optional macro PIPELINED_BARREL_SHIFTER_STICKY_EN: when defined, every beat carries
// a sticky bit, which is the OR of all bits discarded by the shift. When undefined,
// out_sticky is tied to 0 and no sticky state exists.
module pipelined_barrel_shifter #(
    parameter int unsigned N  = 8,
    parameter int unsigned SW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_data,
    input  logic [SW-1:0] in_shamt,
    input  logic [1:0]    in_mode,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_data,
    output logic          out_sticky
);

    localparam logic [1:0]   MODE_LSL = 2'b00;
    localparam logic [1:0]   MODE_LSR = 2'b01;
    localparam logic [1:0]   MODE_ASR = 2'b10;
    localparam logic [1:0]   MODE_ROR = 2'b11;
    localparam logic [N-1:0] ALL_ONES = {N{1'b1}};

    // Shift one operand by a fixed amount sh (0 < sh <= N/2) in the given mode.
    function automatic logic [N-1:0] shift_data(input logic [N-1:0] d,
                                                input logic [1:0]   mode,
                                                input logic         sign,
                                                input int unsigned  sh);
        logic [N-1:0] res;
        res = d;
        case (mode)
            MODE_LSL: res = d << sh;
            MODE_LSR: res = d >> sh;
            MODE_ASR: res = (d >> sh) | (sign ? ~(ALL_ONES >> sh) : '0);
            MODE_ROR: res = (d >> sh) | (d << (N - sh));
            default:  res = d;
        endcase
        return res;
    endfunction

`ifdef PIPELINED_BARREL_SHIFTER_STICKY_EN
    // OR of the bits that fall off the operand for a fixed shift of sh.
    function automatic logic shift_lost(input logic [N-1:0] d,
                                        input logic [1:0]   mode,
                                        input int unsigned  sh);
        logic lost;
        lost = 1'b0;
        case (mode)
            MODE_LSL: lost = |(d & ~(ALL_ONES >> sh));
            MODE_LSR: lost = |(d & ~(ALL_ONES << sh));
            MODE_ASR: lost = |(d & ~(ALL_ONES << sh));
            default:  lost = 1'b0;
        endcase
        return lost;
    endfunction
`endif

    // Stage registers
    logic [SW-1:0] valid_q, valid_d;
    logic [N-1:0]  data_q  [SW];
    logic [N-1:0]  data_d  [SW];
    logic [SW-1:0] shamt_q [SW];
    logic [SW-1:0] shamt_d [SW];
    logic [1:0]    mode_q  [SW];
    logic [1:0]    mode_d  [SW];
    logic          sign_q  [SW];
    logic          sign_d  [SW];
`ifdef PIPELINED_BARREL_SHIFTER_STICKY_EN
    logic          sticky_q [SW];
    logic          sticky_d [SW];
    logic          src_sticky [SW];
    logic          lost [SW];
`endif

    // Per-stage upstream view and the shifted payload
    logic          src_valid [SW];
    logic [N-1:0]  src_data  [SW];
    logic [SW-1:0] src_shamt [SW];
    logic [1:0]    src_mode  [SW];
    logic          src_sign  [SW];
    logic [N-1:0]  shifted   [SW];
    logic [SW-1:0] ready;

    // Stage 0 is fed by the input port. Its sign is the operand's original MSB.
    assign src_valid[0] = in_valid;
    assign src_data[0]  = in_data;
    assign src_shamt[0] = in_shamt;
    assign src_mode[0]  = in_mode;
    assign src_sign[0]  = in_data[N-1];
`ifdef PIPELINED_BARREL_SHIFTER_STICKY_EN
    assign src_sticky[0] = 1'b0;
`endif

    // Stage k (k > 0) is fed by stage k-1
    for (genvar k = 1; k < SW; k++) begin : g_link
        assign src_valid[k] = valid_q[k-1];
        assign src_data[k]  = data_q[k-1];
        assign src_shamt[k] = shamt_q[k-1];
        assign src_mode[k]  = mode_q[k-1];
        assign src_sign[k]  = sign_q[k-1];
`ifdef PIPELINED_BARREL_SHIFTER_STICKY_EN
        assign src_sticky[k] = sticky_q[k-1];
`endif
    end

    // Stage k shifts by 2^k when shift-amount bit k is set
    for (genvar k = 0; k < SW; k++) begin : g_step
        localparam int unsigned SH = 1 << k;
        assign shifted[k] = src_shamt[k][k]
                          ? shift_data(src_data[k], src_mode[k], src_sign[k], SH)
                          : src_data[k];
`ifdef PIPELINED_BARREL_SHIFTER_STICKY_EN
        assign lost[k] = src_shamt[k][k] && shift_lost(src_data[k], src_mode[k], SH);
`endif
    end

    // Stage k can load when some stage at or after it is empty, or when the sink takes the oldest beat
    for (genvar k = 0; k < SW; k++) begin : g_ready
        assign ready[k] = ~(&valid_q[SW-1:k]) | out_ready;
    end

    // Next state: a ready stage takes its upstream beat and a stalled stage holds
    always_comb begin
        valid_d = valid_q;
        for (int k = 0; k < int'(SW); k++) begin
            data_d[k]  = data_q[k];
            shamt_d[k] = shamt_q[k];
            mode_d[k]  = mode_q[k];
            sign_d[k]  = sign_q[k];
`ifdef PIPELINED_BARREL_SHIFTER_STICKY_EN
            sticky_d[k] = sticky_q[k];
`endif
            if (ready[k]) begin
                valid_d[k] = src_valid[k];
                if (src_valid[k]) begin
                    data_d[k]  = shifted[k];
                    shamt_d[k] = src_shamt[k];
                    mode_d[k]  = src_mode[k];
                    sign_d[k]  = src_sign[k];
`ifdef PIPELINED_BARREL_SHIFTER_STICKY_EN
                    sticky_d[k] = src_sticky[k] | lost[k];
`endif
                end
            end
        end
    end

    // Stage registers with synchronous reset that flushes every in-flight beat
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int k = 0; k < int'(SW); k++) begin
                data_q[k]  <= '0;
                shamt_q[k] <= '0;
                mode_q[k]  <= '0;
                sign_q[k]  <= 1'b0;
`ifdef PIPELINED_BARREL_SHIFTER_STICKY_EN
                sticky_q[k] <= 1'b0;
`endif
            end
        end else begin
            valid_q <= valid_d;
            for (int k = 0; k < int'(SW); k++) begin
                data_q[k]  <= data_d[k];
                shamt_q[k] <= shamt_d[k];
                mode_q[k]  <= mode_d[k];
                sign_q[k]  <= sign_d[k];
`ifdef PIPELINED_BARREL_SHIFTER_STICKY_EN
                sticky_q[k] <= sticky_d[k];
`endif
            end
        end
    end

    assign in_ready  = ready[0];
    assign out_valid = valid_q[SW-1];
    assign out_data  = data_q[SW-1];
`ifdef PIPELINED_BARREL_SHIFTER_STICKY_EN
    assign out_sticky = sticky_q[SW-1];
`else
    assign out_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Self-checking bench for pipelined_barrel_shifter (N=8).
// The expected sticky value follows PIPELINED_BARREL_SHIFTER_STICKY_EN.
module tb_pipelined_barrel_shifter;
    localparam int unsigned N  = 8;
    localparam int unsigned SW = 3;
`ifdef PIPELINED_BARREL_SHIFTER_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, out_valid, out_ready, out_sticky;
    logic [7:0] in_data, out_data;
    logic [2:0] in_shamt;
    logic [1:0] in_mode;

    pipelined_barrel_shifter #(.N(N)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_shamt(in_shamt), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_sticky(out_sticky)
    );

    always #5 clk = ~clk;

    typedef struct { logic [7:0] d; logic st; int acc; } exp_t;
    typedef struct { logic [7:0] d; logic [2:0] s; logic [1:0] m; logic [7:0] ed; logic es; } vec_t;

    exp_t       sb[$];
    exp_t       e;
    int         n_cmp = 0, n_fail = 0, cyc = 0;
    bit         chk_lat = 1'b0, rdy_rand = 1'b0;
    logic [7:0] nxt_d;
    logic       nxt_st;
    bit         hold_v = 1'b0;
    logic [7:0] hold_d;
    logic       hold_st;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: whole shift in one step on a widened operand
    function automatic logic [8:0] model(input logic [7:0] d, input logic [2:0] s, input logic [1:0] m);
        logic [15:0] w;
        logic [7:0]  r;
        logic        st;
        case (m)
            2'd0: begin w = {8'h00, d} << s; r = w[7:0];  st = |w[15:8]; end
            2'd1: begin w = {d, 8'h00} >> s; r = w[15:8]; st = |w[7:0];  end
            2'd2: begin w = $signed({d, 8'h00}) >>> s; r = w[15:8]; st = |w[7:0]; end
            default: begin w = {d, d} >> s; r = w[7:0]; st = 1'b0; end
        endcase
        return {st & STICKY, r};
    endfunction

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        if (rdy_rand) out_ready = 1'($urandom_range(0, 1));
    end

    // Monitor: handshake rules, hold stability, ordering and latency
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            hold_v = 1'b0;
        end else begin
            check("in_ready", {31'd0, in_ready}, {31'd0, !(sb.size() == int'(SW) && !out_ready)});
            if (hold_v) begin
                check("hold_valid", {31'd0, out_valid}, 32'd1);
                check("hold_data", {24'd0, out_data}, {24'd0, hold_d});
                check("hold_sticky", {31'd0, out_sticky}, {31'd0, hold_st});
            end
            if (sb.size() == 0) begin
                check("idle_out_valid", {31'd0, out_valid}, 32'd0);
            end else if (out_valid && out_ready) begin
                e = sb.pop_front();
                check("out_data", {24'd0, out_data}, {24'd0, e.d});
                check("out_sticky", {31'd0, out_sticky}, {31'd0, e.st});
                if (chk_lat) check("latency", 32'(cyc - e.acc), SW);
            end
            if (in_valid && in_ready) sb.push_back('{nxt_d, nxt_st, cyc});
            hold_v  = out_valid && !out_ready;
            hold_d  = out_data;
            hold_st = out_sticky;
        end
    end

    task automatic send(input logic [7:0] d, input logic [2:0] s, input logic [1:0] m,
                        input logic [7:0] ed, input logic es);
        bit acc = 1'b0;
        in_valid = 1'b1; in_data = d; in_shamt = s; in_mode = m;
        nxt_d = ed; nxt_st = es;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!acc) begin
            n_cmp++; n_fail++;
            $display("FAIL accept_timeout: got no acceptance, want acceptance within 200 cycles");
        end
    endtask

    task automatic send_model(input logic [7:0] d, input logic [2:0] s, input logic [1:0] m);
        logic [8:0] r;
        r = model(d, s, m);
        send(d, s, m, r[7:0], r[8]);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && sb.size() > 0; i++) @(posedge clk);
        #1;
        check("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    vec_t tbl[16];
    int   t0;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of test, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_data = '0; in_shamt = '0; in_mode = '0; nxt_d = '0; nxt_st = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", {24'd0, out_data}, 32'd0);
        check("rst_out_sticky", {31'd0, out_sticky}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Directed vectors: mode sweep, ASR sign fill, shift by zero, extremes
        tbl[0]  = '{8'h81, 3'd1, 2'd0, 8'h02, 1'b1};
        tbl[1]  = '{8'h81, 3'd1, 2'd1, 8'h40, 1'b1};
        tbl[2]  = '{8'h81, 3'd1, 2'd2, 8'hC0, 1'b1};
        tbl[3]  = '{8'h81, 3'd1, 2'd3, 8'hC0, 1'b0};
        tbl[4]  = '{8'h90, 3'd2, 2'd2, 8'hE4, 1'b0};
        tbl[5]  = '{8'h80, 3'd7, 2'd2, 8'hFF, 1'b0};
        tbl[6]  = '{8'h7F, 3'd7, 2'd2, 8'h00, 1'b1};
        tbl[7]  = '{8'h81, 3'd3, 2'd1, 8'h10, 1'b1};
        tbl[8]  = '{8'hA5, 3'd0, 2'd0, 8'hA5, 1'b0};
        tbl[9]  = '{8'hA5, 3'd0, 2'd1, 8'hA5, 1'b0};
        tbl[10] = '{8'hA5, 3'd0, 2'd2, 8'hA5, 1'b0};
        tbl[11] = '{8'hA5, 3'd0, 2'd3, 8'hA5, 1'b0};
        tbl[12] = '{8'h01, 3'd7, 2'd3, 8'h02, 1'b0};
        tbl[13] = '{8'h01, 3'd7, 2'd0, 8'h80, 1'b0};
        tbl[14] = '{8'hFF, 3'd7, 2'd0, 8'h80, 1'b1};
        tbl[15] = '{8'h96, 3'd4, 2'd3, 8'h69, 1'b0};
        chk_lat = 1'b1;
        for (int i = 0; i < 16; i++)
            send(tbl[i].d, tbl[i].s, tbl[i].m, tbl[i].ed, tbl[i].es & STICKY);
        drain();

        // Exhaustive back-to-back stream: one acceptance per cycle
        t0 = cyc;
        for (int m = 0; m < 4; m++)
            for (int s = 0; s < 8; s++)
                for (int d = 0; d < 256; d++)
                    send_model(8'(d), 3'(s), 2'(m));
        check("throughput_cycles", 32'(cyc - t0), 32'd8192);
        drain();

        // Backpressure: stall the sink for 10 cycles while streaming
        chk_lat = 1'b0;
        fork
            for (int i = 0; i < 12; i++)
                send_model(8'($urandom), 3'($urandom), 2'($urandom));
            begin
                repeat (3) @(posedge clk);
                #2 out_ready = 1'b0;
                repeat (10) @(posedge clk);
                #2;
                check("stall_in_ready", {31'd0, in_ready}, 32'd0);
                check("stall_out_valid", {31'd0, out_valid}, 32'd1);
                out_ready = 1'b1;
            end
        join
        drain();

        // Random sink readiness with random source gaps
        rdy_rand = 1'b1;
        for (int i = 0; i < 300; i++) begin
            send_model(8'($urandom), 3'($urandom), 2'($urandom));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        rdy_rand = 1'b0;
        @(posedge clk);
        #2 out_ready = 1'b1;
        drain();

        // Reset with three beats in flight: none may emerge afterwards
        chk_lat = 1'b1;
        send_model(8'h11, 3'd1, 2'd0);
        send_model(8'h22, 3'd2, 2'd1);
        send_model(8'h33, 3'd3, 2'd3);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("flush_out_valid", {31'd0, out_valid}, 32'd0);
        check("flush_out_data", {24'd0, out_data}, 32'd0);
        check("flush_out_sticky", {31'd0, out_sticky}, 32'd0);
        check("flush_in_ready", {31'd0, in_ready}, 32'd1);
        idle(10);
        send_model(8'hC3, 3'd5, 2'd2);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pipelined_barrel_shifter.md
# pipelined_barrel_shifter

- Parametrised, multi-mode barrel shifter, pipelined one stage per shift-amount bit, with valid/ready handshakes on input and output.
- Generalises the team's combinational arithmetic right shifter:
  - any power-of-two width;
  - full shift range 0..N-1;
  - four modes: LSL, LSR, ASR, ROR;
  - registered stages with backpressure.
- Sits in the datapath between operand issue and the writeback/result FIFO.

## Interface

- `N`, default 8: data width; power of two, ≥ 2.
- `SW`, default `$clog2(N)`: shift-amount width and pipeline depth; derived, do not override.

- `clk` input, 1 bit: single clock, rising edge.
- `rst` input, 1 bit: reset, synchronous, active-high.
- `in_valid` input, 1 bit: input beat present.
- `in_ready` output, 1 bit: pipeline can accept a beat this cycle.
- `in_data` input, N bits: operand.
- `in_shamt` input, SW bits: shift amount, unsigned.
- `in_mode` input, 2 bits: 00 LSL, 01 LSR, 10 ASR, 11 ROR.
- `out_valid` output, 1 bit: result present.
- `out_ready` input, 1 bit: downstream accepts result.
- `out_data` output, N bits: shifted result.
- `out_sticky` output, 1 bit: OR of all bits discarded by the shift.

## Operation

- Stage k (k = 0..SW-1) has registers for valid, data, remaining shamt bits, mode and sticky.
- When `shamt[k]` is set, stage k shifts by 2^k:
  - LSL: shift left, zero fill.
  - LSR: shift right, zero fill.
  - ASR: shift right, fill with the operand's original MSB (sign carried from stage 0).
  - ROR: rotate right; no bits are discarded.
- Sticky handling:
  - Each stage ORs the bits it discards into the sticky bit carried with the beat.
  - Sticky is 0 for ROR and for shift amount 0.
- Transfer rules:
  - Input beat accepted iff `in_valid && in_ready`.
  - Output beat consumed iff `out_valid && out_ready`.
- Per-stage ready, so bubbles collapse:
  - `ready[SW-1] = !valid[SW-1] || out_ready`.
  - `ready[k] = !valid[k] || ready[k+1]`.
  - `in_ready = ready[0]`.
- A stage with ready = 0 holds all its registers unchanged.
- The stage feeding a stalled stage may not overwrite it.
- Once `out_valid` is high, `out_data`, `out_sticky` and `out_valid` stay stable until consumed. No beat is dropped or duplicated.
- Results leave in acceptance order.
- Mode, shamt and data are captured at acceptance. Input changes after acceptance do not affect in-flight beats.

## Timing

- Latency: a beat accepted at edge t appears with `out_valid` high after edge t+SW when there are no stalls. N=8 gives 3 cycles; N=32 gives 5 cycles.
- Throughput: one beat per cycle while `out_ready` stays high.
- Reset, at the edge where `rst` = 1:
  - All stage valids clear.
  - `out_valid` = 0, `out_data` = 0, `out_sticky` = 0.
  - `in_ready` = 1 in the first cycle after reset.
- Reset mid-operation discards every in-flight beat; nothing is emitted afterwards for those beats.
- Full pipeline with `out_ready` = 0: `in_ready` = 0 combinationally in the same cycle. There is no combinational path from `in_valid` to `in_ready`.
- Simultaneous events: a full pipeline with `out_ready` = 1 accepts a new beat in the same cycle the oldest leaves. `in_ready` = 1 in that case.
- Shift amount 0 in any mode: `out_data` = `in_data`, `out_sticky` = 0.

## Configuration

- Macro: `PIPELINED_BARREL_SHIFTER_STICKY_EN`.
- Defined: sticky logic is compiled in and `out_sticky` behaves as above.
- Undefined: sticky registers are not instantiated and `out_sticky` is tied to 0. Data path, latency and handshake are identical.

## Test plan

All scenarios use N=8 with the sticky macro defined unless noted.

- Mode sweep at shamt 1, operand 0x81:
  - LSL gives 0x02, sticky 1.
  - LSR gives 0x40, sticky 1.
  - ASR gives 0xC0, sticky 1.
  - ROR gives 0xC0, sticky 0.
  - Each result arrives exactly 3 cycles after acceptance.
- ASR sign fill:
  - 0x90 by 2 gives 0xE4, sticky 0.
  - 0x80 by 7 gives 0xFF, sticky 0.
  - 0x7F by 7 gives 0x00, sticky 1.
  - LSR 0x81 by 3 gives 0x10, sticky 1.
- Exhaustive streaming:
  - All 256 operands × 8 shamts × 4 modes back-to-back with `out_ready` = 1.
  - Every result matches the reference model, in order, with one result per cycle after a 3-cycle fill.
- Backpressure:
  - Hold `out_ready` = 0 for 10 cycles while streaming.
  - `in_ready` falls once 3 beats are held.
  - `out_data` stays stable throughout.
  - After release, all beats emerge in order with no loss or duplication.
  - Random `out_ready` toggling with random `in_valid` gives the same result.
- Reset mid-stream:
  - Assert `rst` for one cycle with 3 beats in flight.
  - Next cycle: `out_valid` = 0, `out_data` = 0, `in_ready` = 1.
  - None of the flushed beats ever appears.
- Macro undefined:
  - Rerun the mode sweep.
  - Identical data and latency; `out_sticky` constantly 0.
